// File: rtl/aux_instr_burst.sv
// Auxiliary instruction burst fetcher: reads num_instr words over AXI4 in
// 4KB-safe INCR bursts, buffers them, and streams them out on AXI4-Stream.

// Simple first-word-fall-through AXI-Stream FIFO.
module fifo_axis #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  assign s_tready = !((wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]));
  assign m_tvalid = (wptr != rptr);
  assign m_tdata  = mem[rptr[PW-1:0]];
  assign wr_en    = s_tvalid && s_tready;
  assign rd_en    = m_tvalid && m_tready;

  // Storage array; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[PW-1:0]] <= s_tdata;
  end

  // Read/write pointers with wrap bit for full/empty distinction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end
endmodule

// state  | meaning
// IDLE   | waiting for a rising edge on ap_start
// ISSUE  | issuing AR bursts until every word has been requested
// DRAIN  | all ARs issued, waiting for the final output handshake
// DONE   | one-cycle ap_done pulse, then back to IDLE
module aux_instr_burst #(
  parameter int AXI_ADDR_WIDTH   = 64,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int INSTR_FIFO_DEPTH = 256,
  parameter int MAX_BURST_LEN    = 16,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ap_start,
  output logic                      ap_done,
  output logic                      ap_idle,
  output logic                      ap_ready,
  input  logic [31:0]               num_instr,
  input  logic [63:0]               base_addr,
  output logic [31:0]               status,
  input  logic                      m_axi_arready,
  output logic                      m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_rready,
  input  logic                      m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_instr_tready,
  output logic                      m_instr_tvalid,
  output logic [AXI_DATA_WIDTH-1:0] m_instr_tdata,
  output logic                      m_instr_tlast
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int LW    = $clog2(MAX_BURST_LEN) + 1;
  localparam int CW    = $clog2(INSTR_FIFO_DEPTH) + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(AXI_ADDR_WIDTH'(BYTES - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      start_q;
  logic                      start_edge;
  logic                      job_load;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [31:0]               rem_ar;
  logic [31:0]               rem_out;
  logic [LW-1:0]             ar_len_q;
  logic [CW-1:0]             credits;
  logic [CW-1:0]             cred_dec;
  logic [CW-1:0]             cred_inc;
  logic [OW-1:0]             outstanding;
  logic [15:0]               out_hs_cnt;
  logic [7:0]                ar_hs_cnt;
  logic                      err_flag;
  logic [1:0]                err_resp;
  logic [12:0]               beats_to_4k;
  logic [31:0]               len_c;
  logic [31:0]               out_ext;
  logic [2:0]                out_sat;
  logic                      can_issue;
  logic                      ar_fire;
  logic                      r_fire;
  logic                      out_fire;
  logic                      last_fire;

  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;

  assign start_edge = ap_start && !start_q;
  assign job_load   = (state == S_IDLE) && start_edge;
  assign ar_fire    = m_axi_arvalid && m_axi_arready;
  assign r_fire     = m_axi_rvalid && m_axi_rready;
  assign out_fire   = m_instr_tvalid && m_instr_tready;
  assign last_fire  = out_fire && m_instr_tlast;

  // tlast comes from the remaining-word down-counter, never from rlast.
  assign m_instr_tlast = m_instr_tvalid && (rem_out == 32'd1);

  fifo_axis #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (INSTR_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (m_axi_rvalid),
    .s_tready (m_axi_rready),
    .s_tdata  (m_axi_rdata),
    .m_tvalid (m_instr_tvalid),
    .m_tready (m_instr_tready),
    .m_tdata  (m_instr_tdata)
  );

  // Next burst length: bounded by max burst, words left and the 4KB page end.
  always_comb begin
    beats_to_4k = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
    len_c       = 32'(MAX_BURST_LEN);
    if (rem_ar < len_c) len_c = rem_ar;
    if (32'(beats_to_4k) < len_c) len_c = 32'(beats_to_4k);
    can_issue = (state == S_ISSUE) && !m_axi_arvalid && (rem_ar != 32'd0) &&
                (32'(credits) >= len_c) &&
                (32'(outstanding) < 32'(MAX_OUTSTANDING));
    cred_dec = ar_fire ? CW'(ar_len_q) : '0;
    cred_inc = out_fire ? CW'(1) : '0;
    out_ext  = 32'(outstanding);
    out_sat  = (out_ext > 32'd7) ? 3'd7 : out_ext[2:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_next = state;
    ap_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) state_next = (num_instr == 32'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (last_fire)              state_next = S_DONE;
        else if (rem_ar == 32'd0)   state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_fire) state_next = S_DONE;
      end
      S_DONE: begin
        ap_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ap_ready = ap_done;
  assign ap_idle  = (state == S_IDLE) && !ap_start;
  assign status   = {out_hs_cnt, ar_hs_cnt, err_flag, out_sat, state, err_resp};

  // AR issue, credit/outstanding accounting and status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q       <= 1'b0;
      addr          <= '0;
      rem_ar        <= '0;
      rem_out       <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      ar_len_q      <= '0;
      credits       <= CW'(INSTR_FIFO_DEPTH);
      outstanding   <= '0;
      out_hs_cnt    <= '0;
      ar_hs_cnt     <= '0;
      err_flag      <= 1'b0;
      err_resp      <= '0;
    end else begin
      start_q <= ap_start;
      if (job_load) begin
        addr       <= base_addr[AXI_ADDR_WIDTH-1:0] & ALIGN_MASK;
        rem_ar     <= num_instr;
        rem_out    <= num_instr;
        credits    <= CW'(INSTR_FIFO_DEPTH);
        out_hs_cnt <= '0;
        ar_hs_cnt  <= '0;
        err_flag   <= 1'b0;
        err_resp   <= '0;
      end else begin
        if (can_issue) begin
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= addr;
          m_axi_arlen   <= 8'(len_c - 32'd1);
          ar_len_q      <= LW'(len_c);
        end else if (ar_fire) begin
          m_axi_arvalid <= 1'b0;
          addr          <= addr + (AXI_ADDR_WIDTH'(ar_len_q) << SZ);
          rem_ar        <= rem_ar - 32'(ar_len_q);
          ar_hs_cnt     <= ar_hs_cnt + 8'd1;
        end
        credits <= credits - cred_dec + cred_inc;
        if (out_fire) begin
          rem_out    <= rem_out - 32'd1;
          out_hs_cnt <= out_hs_cnt + 16'd1;
        end
        if (r_fire && (m_axi_rresp != 2'b00) && !err_flag) begin
          err_flag <= 1'b1;
          err_resp <= m_axi_rresp;
        end
      end
      if (ar_fire && !(r_fire && m_axi_rlast))      outstanding <= outstanding + 1'b1;
      else if (!ar_fire && r_fire && m_axi_rlast)   outstanding <= outstanding - 1'b1;
    end
  end
endmodule
